// File: rtl/i2s_unit_if.sv
// i2s_unit_if: sample-pair input handshake and I2S serial outputs of i2s_unit.
// Carries underrun_out only when I2S_UNDERRUN_EN is defined.
interface i2s_unit_if #(parameter int DATA_W = 24);
  logic              play_in;
  logic              tick_in;
  logic [DATA_W-1:0] audio0_in;
  logic [DATA_W-1:0] audio1_in;
  logic              req_out;
  logic              sck_out;
  logic              ws_out;
  logic              sdo_out;
`ifdef I2S_UNDERRUN_EN
  logic              underrun_out;
  modport master (output play_in, tick_in, audio0_in, audio1_in,
                  input req_out, sck_out, ws_out, sdo_out, underrun_out);
  modport slave  (input play_in, tick_in, audio0_in, audio1_in,
                  output req_out, sck_out, ws_out, sdo_out, underrun_out);
`else
  modport master (output play_in, tick_in, audio0_in, audio1_in,
                  input req_out, sck_out, ws_out, sdo_out);
  modport slave  (input play_in, tick_in, audio0_in, audio1_in,
                  output req_out, sck_out, ws_out, sdo_out);
`endif
endinterface

// File: rtl/i2s_unit.sv
// i2s_unit: one-pair buffered stereo input serialised as Philips I2S frames.
// Optional I2S_UNDERRUN_EN adds underrun_out, pulsed when a load finds the buffer empty.
module i2s_unit #(
  parameter int DATA_W  = 24,
  parameter int SLOT_W  = 32,
  parameter int SCK_DIV = 4
) (
  input logic        clk,
  input logic        rst,
  i2s_unit_if.slave  bus
);
  localparam int FRM_W = 2 * SLOT_W;
  localparam int DIV_W = $clog2(SCK_DIV);
  localparam int BIT_W = $clog2(FRM_W);
  localparam int PAD   = SLOT_W - 1 - DATA_W;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRM_W - 1);
  localparam logic [BIT_W-1:0] BIT_SLOT = BIT_W'(SLOT_W);
  typedef enum logic {IDLE, RUN} state_t;
  state_t            r_state, w_next;
  logic [DIV_W-1:0]  r_div;
  logic [BIT_W-1:0]  r_bit;
  logic [FRM_W-1:0]  r_shift;
  logic [DATA_W-1:0] r_buf0, r_buf1;
  logic              r_full, r_req;
  logic              w_wrap, w_end, w_load, w_flush;
  logic [SLOT_W-1:0] w_left, w_right;
  // Each slot leads with the one-bit I2S delay, then MSB-first data, then zero padding.
  assign w_left  = SLOT_W'(r_buf0) << PAD;
  assign w_right = SLOT_W'(r_buf1) << PAD;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_wrap  = r_state == RUN && r_div == DIV_LAST;
    w_end   = w_wrap && r_bit == BIT_LAST;
    w_load  = bus.play_in && (r_state == IDLE || w_end);
    w_flush = w_end && !bus.play_in;
    w_next  = w_load ? RUN : (w_flush ? IDLE : r_state);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_buf0  <= '0;
      r_buf1  <= '0;
      r_full  <= 1'b0;
      r_req   <= 1'b0;
    end else begin
      r_req   <= w_load;
      r_div   <= (r_state == IDLE || w_wrap) ? '0 : r_div + 1'b1;
      r_bit   <= (r_state == IDLE || w_end) ? '0 : (w_wrap ? r_bit + 1'b1 : r_bit);
      r_shift <= w_load ? (r_full ? {w_left, w_right} : '0) : (w_wrap ? r_shift << 1 : r_shift);
      r_full  <= !w_flush && (bus.tick_in || (r_full && !w_load));
      if (bus.tick_in) begin
        r_buf0 <= bus.audio0_in;
        r_buf1 <= bus.audio1_in;
      end
    end
`ifdef I2S_UNDERRUN_EN
  logic r_und;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_und <= 1'b0;
    else     r_und <= w_load && !r_full;
  assign bus.underrun_out = r_und;
`endif
  assign bus.req_out = r_req;
  assign bus.sck_out = r_state == RUN && r_div >= DIV_HALF;
  assign bus.ws_out  = r_state == RUN && r_bit >= BIT_SLOT;
  assign bus.sdo_out = r_state == RUN && r_shift[FRM_W-1];
endmodule

// File: tb/tb_i2s_unit.sv
// tb_i2s_unit: vector table plus frame scoreboard for i2s_unit at default parameters.
module tb_i2s_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  i2s_unit_if #(.DATA_W(24)) bus();
  i2s_unit #(.DATA_W(24), .SLOT_W(32), .SCK_DIV(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  typedef struct {
    int          nt;
    logic [23:0] a0, a1, b0, b1, e0, e1;
    logic        und;
  } vec_t;
  vec_t tbl[5];
  logic [63:0] exp_q[$];
  localparam logic [63:0] WS_EXP = {32'h0, 32'hFFFF_FFFF};
  int vecs = 0, errs = 0, frames = 0, reqs = 0;
  longint cyc = 0;
  task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  function automatic logic [63:0] frame(input logic [23:0] l, input logic [23:0] r);
    return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
  endfunction
  function automatic logic [3:0] outs();
    return {bus.req_out, bus.sck_out, bus.ws_out, bus.sdo_out};
  endfunction
  always @(posedge clk) cyc++;
  always @(negedge clk) if (!rst && bus.req_out) reqs++;
  int nb = 0;
  logic psck = 1'b0;
  logic [63:0] frm, wsf, e;
  always @(negedge clk) begin
    if (rst) begin
      nb = 0;
      psck = 1'b0;
    end else begin
      if (bus.sck_out && !psck) begin
        frm = {frm[62:0], bus.sdo_out};
        wsf = {wsf[62:0], bus.ws_out};
        nb++;
        if (nb == 64) begin
          nb = 0;
          frames++;
          if (exp_q.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL unexpected_frame: got %h expected none", frm);
          end else begin
            e = exp_q.pop_front();
            check("frame", frm, e);
            check("ws_frame", wsf, WS_EXP);
          end
        end
      end
      psck = bus.sck_out;
    end
  end
  task automatic tick(input logic [23:0] l, input logic [23:0] r);
    bus.tick_in = 1'b1;
    bus.audio0_in = l;
    bus.audio1_in = r;
    @(negedge clk);
    bus.tick_in = 1'b0;
  endtask
  task automatic wait_req(output longint t);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.req_out && k < 600);
    check("req_seen", 64'(bus.req_out), 64'd1);
    t = cyc;
  endtask
  task automatic wait_frames(input int target);
    int k = 0;
    while (frames < target && k < 1200) begin
      @(negedge clk);
      k++;
    end
    check("frame_count", 64'(frames), 64'(target));
  endtask
  task automatic chk_und(input logic x);
`ifdef I2S_UNDERRUN_EN
    check("underrun", 64'(bus.underrun_out), 64'(x));
`else
    if (x === 1'bx) $display("unused");
`endif
  endtask
  task automatic apply_vec(input vec_t v);
    int r0, tgt;
    if (v.nt > 0) tick(v.a0, v.a1);
    if (v.nt > 1) tick(v.b0, v.b1);
    exp_q.push_back(frame(v.e0, v.e1));
    tgt = frames + 1;
    r0 = reqs;
    bus.play_in = 1'b1;
    @(negedge clk);
    check("req_first_run", 64'(bus.req_out), 64'd1);
    chk_und(v.und);
    bus.play_in = 1'b0;
    wait_frames(tgt);
    repeat (4) @(negedge clk);
    check("idle_outs", 64'(outs()), 64'd0);
    check("req_once", 64'(reqs - r0), 64'd1);
  endtask
  initial begin
    longint t0, t1;
    int tgt, r0;
    logic [3:0] bad;
    tbl[0] = '{1, 24'hA5A5A5, 24'h5A5A5A, 24'h0, 24'h0, 24'hA5A5A5, 24'h5A5A5A, 1'b0};
    tbl[1] = '{0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 1'b1};
    tbl[2] = '{2, 24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h333333, 24'h444444, 1'b0};
    tbl[3] = '{1, 24'hFFFFFF, 24'h000001, 24'h0, 24'h0, 24'hFFFFFF, 24'h000001, 1'b0};
    tbl[4] = '{1, 24'h800000, 24'h7FFFFF, 24'h0, 24'h0, 24'h800000, 24'h7FFFFF, 1'b0};
    bus.play_in = 1'b0;
    bus.tick_in = 1'b0;
    bus.audio0_in = '0;
    bus.audio1_in = '0;
    repeat (3) @(negedge clk);
    check("reset_outs", 64'(outs()), 64'd0);
    chk_und(1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 64'(outs()), 64'd0);
    tick(24'hC0FFEE, 24'h123456);
    bus.play_in = 1'b1;
    exp_q.push_back(frame(24'hC0FFEE, 24'h123456));
    wait_req(t0);
    repeat (150) @(negedge clk);
    check("ws_mid_right", 64'(bus.ws_out), 64'd1);
    #2 rst = 1'b1;
    #1 check("async_reset_outs", 64'(outs()), 64'd0);
    exp_q.delete();
    bad = '0;
    repeat (3) begin
      @(negedge clk);
      bad |= outs();
    end
    check("held_in_reset", 64'(bad), 64'd0);
    bus.play_in = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) apply_vec(tbl[i]);
    exp_q.push_back(frame(24'h0, 24'h0));
    exp_q.push_back(frame(24'h0, 24'h0));
    tgt = frames + 2;
    bus.play_in = 1'b1;
    wait_req(t0);
    chk_und(1'b1);
    wait_req(t1);
    chk_und(1'b1);
    check("req_period", 64'(t1 - t0), 64'd256);
    repeat (40) @(negedge clk);
    bus.play_in = 1'b0;
    tick(24'hABCDEF, 24'hFEDCBA);
    r0 = reqs;
    wait_frames(tgt);
    bad = '0;
    repeat (300) begin
      @(negedge clk);
      bad |= outs();
    end
    check("idle_quiet", 64'(bad), 64'd0);
    check("no_req_after_stop", 64'(reqs - r0), 64'd0);
    exp_q.push_back(frame(24'h0, 24'h0));
    tgt = frames + 1;
    bus.play_in = 1'b1;
    @(negedge clk);
    check("req_replay", 64'(bus.req_out), 64'd1);
    chk_und(1'b1);
    bus.play_in = 1'b0;
    wait_frames(tgt);
    repeat (4) @(negedge clk);
    tick(24'h0A0B0C, 24'h0D0E0F);
    exp_q.push_back(frame(24'h0A0B0C, 24'h0D0E0F));
    exp_q.push_back(frame(24'h102030, 24'h405060));
    exp_q.push_back(frame(24'h708090, 24'hA0B0C0));
    tgt = frames + 3;
    bus.play_in = 1'b1;
    @(negedge clk);
    t0 = cyc;
    check("req_e0", 64'(bus.req_out), 64'd1);
    repeat (100) @(negedge clk);
    tick(24'h102030, 24'h405060);
    repeat (154) @(negedge clk);
    tick(24'h708090, 24'hA0B0C0);
    check("req_on_tick_edge", 64'(bus.req_out), 64'd1);
    check("req_e1_time", 64'(cyc - t0), 64'd256);
    chk_und(1'b0);
    wait_req(t1);
    chk_und(1'b0);
    check("req_e2_time", 64'(t1 - t0), 64'd512);
    bus.play_in = 1'b0;
    wait_frames(tgt);
    repeat (4) @(negedge clk);
    check("final_idle", 64'(outs()), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
  initial begin
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
